fir_mac_sequencer: RTL and testbench

//  Controller for a time-multiplexed FIR: one multiplier and one accumulator serve all taps.

---
 rtl/fir_mac_sequencer_pkg.sv | 37 +++
 rtl/fir_mac_sequencer_if.sv | 33 +++
 rtl/fir_mac_sequencer_mac.sv | 45 ++++
 rtl/fir_mac_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_fir_mac_sequencer.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fir_mac_sequencer_pkg.sv
// Shared types and helpers for the time-multiplexed FIR sequencer.
//   seq_state_t : sequencer FSM states
//   NTAPS_DEF   : default tap count
//   Q15_W       : audio sample width (signed Q15)
//   DRAIN_CYC   : cycles between the last tap issue and the output register
//   sat_w/sat16 : signed saturation helpers, also used by other audio blocks
package fir_mac_sequencer_pkg;

   typedef enum logic [2:0] {
      CLEAR = 3'd0,
      IDLE  = 3'd1,
      RUN   = 3'd2,
      DRAIN = 3'd3,
      OUT   = 3'd4
   } seq_state_t;

   localparam int NTAPS_DEF = 32;
   localparam int Q15_W     = 16;
   // RAM read, product register, accumulate
   localparam int DRAIN_CYC = 3;

   // Clamp a sign-extended value into the signed range of a w-bit word.
   function automatic logic signed [63:0] sat_w(input logic signed [63:0] v, input int w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      if (v > hi)      return hi;
      else if (v < lo) return lo;
      else             return v;
   endfunction

   function automatic logic signed [Q15_W-1:0] sat16(input logic signed [63:0] v);
      return Q15_W'(sat_w(v, Q15_W));
   endfunction

endpackage

// File: rtl/fir_mac_sequencer_if.sv
// Sample input stream of the FIR sequencer.
//   x_in        : signed sample
//   x_in_valid  : source offers x_in
//   x_in_ready  : sink can take it
// Handshake: a sample moves on a rising clk edge where x_in_valid and
// x_in_ready are both 1. The sink never consumes data unless both are high;
// the source may withdraw or change x_in while x_in_ready is 0 (such a
// sample is simply dropped and flagged as overrun by the sequencer).
//   master : sample source
//   slave  : sequencer
interface fir_mac_sequencer_if
   import fir_mac_sequencer_pkg::*;
#(
   parameter int DW = Q15_W
) ();

   logic signed [DW-1:0] x_in;
   logic                 x_in_valid;
   logic                 x_in_ready;

   modport master (
      output x_in,
      output x_in_valid,
      input  x_in_ready
   );

   modport slave (
      input  x_in,
      input  x_in_valid,
      output x_in_ready
   );

endinterface

// File: rtl/fir_mac_sequencer_mac.sv
// Shared multiply-accumulate datapath for the FIR sequencer.
//   clk, reset : clock, synchronous active-high reset
//   mul_en     : register a*b into the product register
//   acc_en     : fold the product register into the accumulator
//   acc_clr    : with acc_en, load the product instead of adding (first tap)
//   a, b       : signed sample and coefficient
//   acc        : signed accumulator, wide enough that NTAPS products never wrap
module fir_mac_sequencer_mac
   import fir_mac_sequencer_pkg::*;
#(
   parameter int DW = Q15_W,
   parameter int CW = Q15_W,
   parameter int AW = 5
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      mul_en,
   input  logic                      acc_en,
   input  logic                      acc_clr,
   input  logic signed [DW-1:0]      a,
   input  logic signed [CW-1:0]      b,
   output logic signed [DW+CW+AW-1:0] acc
);

   localparam int PW   = DW + CW;
   localparam int ACCW = DW + CW + AW;

   logic signed [PW-1:0] prod_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         prod_q <= '0;
         acc    <= '0;
      end else begin
         if (mul_en) begin
            prod_q <= PW'(a) * PW'(b);
         end
         if (acc_en) begin
            // Loading on the first tap avoids a separate clear cycle per sample.
            acc <= acc_clr ? ACCW'(prod_q) : acc + ACCW'(prod_q);
         end
      end
   end

endmodule

// File: rtl/fir_mac_sequencer.sv
// Controller for a time-multiplexed FIR: one multiplier and one accumulator
// serve all taps. Samples arrive on a valid/ready stream, are written into an
// external circular sample RAM, convolved against an external coefficient ROM
// and one scaled, saturated Q15 output is produced per accepted sample.
//   clk, reset   : clock, synchronous active-high reset (overrides clear)
//   clear        : zero the history and restart warm-up, any state
//   x_if         : sample input stream (slave side)
//   samp_*       : sample RAM write port and read address (1-cycle read)
//   samp_rdata   : sample RAM read data
//   coef_addr    : coefficient ROM address (1-cycle read)
//   coef_data    : coefficient, signed Q(CW-1)
//   y_out        : last computed output, signed Q15
//   y_out_valid  : 1-cycle strobe once the history is fully warmed up
//   overrun      : 1-cycle strobe the cycle after a refused offer
//   dbg_state    : current FSM state
// Timeline for a sample accepted in cycle 0: RUN 1..NTAPS issues one tap per
// cycle, DRAIN NTAPS+1..NTAPS+3 empties the read/multiply/accumulate pipe,
// OUT at NTAPS+4 presents y_out, IDLE again at NTAPS+5.
module fir_mac_sequencer
   import fir_mac_sequencer_pkg::*;
#(
   parameter  int NTAPS = NTAPS_DEF,
   parameter  int DW    = Q15_W,
   parameter  int CW    = Q15_W,
   localparam int AW    = $clog2(NTAPS)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   clear,
   fir_mac_sequencer_if.slave     x_if,
   output logic                   samp_we,
   output logic [AW-1:0]          samp_waddr,
   output logic signed [DW-1:0]   samp_wdata,
   output logic [AW-1:0]          samp_raddr,
   input  logic signed [DW-1:0]   samp_rdata,
   output logic [AW-1:0]          coef_addr,
   input  logic signed [CW-1:0]   coef_data,
   output logic signed [DW-1:0]   y_out,
   output logic                   y_out_valid,
   output logic                   overrun,
   output seq_state_t             dbg_state
);

   localparam int FW   = $clog2(NTAPS + 1);
   localparam int ACCW = DW + CW + AW;

   seq_state_t state_q, state_d;

   logic [AW-1:0] cidx_q;   // zeroing address in CLEAR
   logic [AW-1:0] k_q;      // tap index in RUN
   logic [AW-1:0] wptr_q;   // slot of the newest sample
   logic [1:0]    dcnt_q;   // DRAIN cycle counter
   logic [FW-1:0] fill_q;   // samples in history, saturates at NTAPS

   // Two-deep valid pipeline matching RAM/ROM read latency and the product
   // register; f* marks the k=0 tap so the accumulator reloads on it.
   logic v1_q, f1_q, v2_q, f2_q;

   logic x_ready;
   logic accept;
   logic drain_last;

   logic signed [ACCW-1:0] acc;
   logic signed [ACCW-1:0] acc_shr;
   logic signed [63:0]     acc_ext;
   logic signed [DW-1:0]   y_sat;

   // clear wins over a simultaneous offer in IDLE: the sample is dropped.
   assign accept     = (state_q == IDLE) && x_if.x_in_valid && !clear;
   assign drain_last = (state_q == DRAIN) && (dcnt_q == 2'(DRAIN_CYC - 1));

   assign x_if.x_in_ready = x_ready;
   assign samp_raddr      = wptr_q - k_q;
   assign coef_addr       = k_q;
   assign dbg_state       = state_q;

   // Arithmetic shift floors; then clamp into the DW-bit signed range.
   assign acc_shr = acc >>> (CW - 1);
   assign acc_ext = 64'(acc_shr);
   assign y_sat   = DW'(sat_w(acc_ext, DW));

   always_comb begin
      state_d    = state_q;
      x_ready    = 1'b0;
      samp_we    = 1'b0;
      samp_waddr = wptr_q;
      samp_wdata = '0;
      unique case (state_q)
         CLEAR: begin
            samp_we    = 1'b1;
            samp_waddr = cidx_q;
            if (cidx_q == AW'(NTAPS - 1)) state_d = IDLE;
         end
         IDLE: begin
            x_ready = 1'b1;
            if (accept) begin
               samp_we    = 1'b1;
               samp_wdata = x_if.x_in;
               state_d    = RUN;
            end
         end
         RUN: begin
            if (k_q == AW'(NTAPS - 1)) state_d = DRAIN;
         end
         DRAIN: begin
            if (drain_last) state_d = OUT;
         end
         OUT: begin
            state_d = IDLE;
         end
         default: begin
            state_d = CLEAR;
         end
      endcase
      if (clear) state_d = CLEAR;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= CLEAR;
         cidx_q      <= '0;
         k_q         <= '0;
         wptr_q      <= '0;
         dcnt_q      <= '0;
         fill_q      <= '0;
         v1_q        <= 1'b0;
         f1_q        <= 1'b0;
         v2_q        <= 1'b0;
         f2_q        <= 1'b0;
         y_out       <= '0;
         y_out_valid <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         state_q     <= state_d;
         overrun     <= x_if.x_in_valid && !x_ready;
         y_out_valid <= 1'b0;

         v1_q <= (state_q == RUN) && !clear;
         f1_q <= (state_q == RUN) && (k_q == '0);
         v2_q <= v1_q && !clear;
         f2_q <= f1_q;

         unique case (state_q)
            CLEAR: cidx_q <= cidx_q + AW'(1);
            IDLE: begin
               k_q    <= '0;
               dcnt_q <= '0;
            end
            RUN: begin
               k_q    <= k_q + AW'(1);
               dcnt_q <= '0;
            end
            DRAIN: begin
               dcnt_q <= dcnt_q + 2'd1;
               // The accumulator is final here; register so OUT presents it.
               if (drain_last && !clear) begin
                  y_out       <= y_sat;
                  // This sample itself completes the fill at NTAPS.
                  y_out_valid <= (fill_q >= FW'(NTAPS - 1));
               end
            end
            OUT: begin
               wptr_q <= wptr_q + AW'(1);
               if (fill_q != FW'(NTAPS)) fill_q <= fill_q + FW'(1);
            end
            default: ;
         endcase

         if (clear) begin
            cidx_q <= '0;
            wptr_q <= '0;
            fill_q <= '0;
         end
      end
   end

   fir_mac_sequencer_mac #(
      .DW (DW),
      .CW (CW),
      .AW (AW)
   ) u_mac (
      .clk     (clk),
      .reset   (reset),
      .mul_en  (v1_q),
      .acc_en  (v2_q),
      .acc_clr (f2_q),
      .a       (samp_rdata),
      .b       (coef_data),
      .acc     (acc)
   );

endmodule

// File: tb/tb_fir_mac_sequencer.sv
module tb_fir_mac_sequencer;
   import fir_mac_sequencer_pkg::*;

   localparam int NTAPS = 32;
   localparam int DW    = 16;
   localparam int CW    = 16;
   localparam int AW    = 5;
   localparam int LAT   = 36;   // accept cycle -> y_out_valid cycle
   localparam int EW    = 48;   // {strobe, due[30:0], value[15:0]}

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset;
   logic clear;
   always #5 clk = ~clk;

   fir_mac_sequencer_if #(.DW(DW)) x_if ();

   logic                 samp_we;
   logic [AW-1:0]        samp_waddr;
   logic signed [DW-1:0] samp_wdata;
   logic [AW-1:0]        samp_raddr;
   logic signed [DW-1:0] samp_rdata;
   logic [AW-1:0]        coef_addr;
   logic signed [CW-1:0] coef_data;
   logic signed [DW-1:0] y_out;
   logic                 y_out_valid;
   logic                 overrun;
   seq_state_t           dbg_state;

   fir_mac_sequencer #(.NTAPS(NTAPS), .DW(DW), .CW(CW)) dut (
      .clk         (clk),
      .reset       (reset),
      .clear       (clear),
      .x_if        (x_if),
      .samp_we     (samp_we),
      .samp_waddr  (samp_waddr),
      .samp_wdata  (samp_wdata),
      .samp_raddr  (samp_raddr),
      .samp_rdata  (samp_rdata),
      .coef_addr   (coef_addr),
      .coef_data   (coef_data),
      .y_out       (y_out),
      .y_out_valid (y_out_valid),
      .overrun     (overrun),
      .dbg_state   (dbg_state)
   );

   // External RAM / ROM with registered reads
   logic signed [DW-1:0] samp_mem [NTAPS];
   logic signed [CW-1:0] coef_rom [NTAPS];

   always @(posedge clk) begin
      if (samp_we) samp_mem[samp_waddr] <= samp_wdata;
      samp_rdata <= samp_mem[samp_raddr];
      coef_data  <= coef_rom[coef_addr];
   end

   // ---------------- scoreboard state ----------------
   int unsigned          n_total = 0;
   int unsigned          n_bad   = 0;
   int unsigned          cyc     = 0;
   logic [EW-1:0]        exp_q [$];
   logic signed [DW-1:0] hist  [$];   // newest first
   int                   fills   = 0;
   logic                 ovr_exp = 1'b0;
   logic signed [DW-1:0] last_y  = '0;

   function automatic void chk(input string name, input longint act, input longint exp);
      n_total++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got=%0d want=%0d (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Reference: y = clamp(floor(sum coef[k]*x[n-k] / 2^15)), strobe once NTAPS seen.
   function automatic void model_accept(input logic signed [DW-1:0] x);
      longint s;
      logic   strobe;
      logic [30:0] due;
      hist.push_front(x);
      if (hist.size() > NTAPS) void'(hist.pop_back());
      if (fills < NTAPS) fills++;
      s = 0;
      for (int k = 0; k < hist.size(); k++) s += longint'(coef_rom[k]) * longint'(hist[k]);
      s = s >>> (CW - 1);
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
      strobe = (fills >= NTAPS);
      due    = 31'(cyc + LAT);
      exp_q.push_back({strobe, due, 16'(s)});
   endfunction

   // Stimulus observer: feeds the reference model from the handshake.
   always @(posedge clk) begin
      cyc     <= cyc + 1;
      ovr_exp <= !reset && x_if.x_in_valid && !x_if.x_in_ready;
      if (reset) begin
         hist.delete();
         exp_q.delete();
         fills = 0;
      end else if (clear) begin
         hist.delete();
         fills = 0;
         while (exp_q.size() > 0 && exp_q[exp_q.size()-1][46:16] > cyc[30:0])
            exp_q.delete(exp_q.size() - 1);
      end else if (x_if.x_in_valid && x_if.x_in_ready) begin
         model_accept(x_if.x_in);
      end
   end

   // Output monitor
   always @(negedge clk) begin
      logic [EW-1:0] e;
      if (!reset) begin
         chk("overrun", longint'(overrun), longint'(ovr_exp));
         if (exp_q.size() > 0 && exp_q[0][46:16] < cyc[30:0]) begin
            e = exp_q.pop_front();
            chk("missed_output_due", longint'(cyc), longint'(e[46:16]));
         end
         if (exp_q.size() > 0 && exp_q[0][46:16] == cyc[30:0]) begin
            e = exp_q.pop_front();
            chk("y_out_valid", longint'(y_out_valid), longint'(e[47]));
            chk("y_out", longint'(y_out), longint'($signed(e[15:0])));
            last_y = $signed(e[15:0]);
         end else if (y_out_valid) begin
            chk("unexpected_strobe", 1, 0);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_ready(input int budget);
      int n = 0;
      while (!x_if.x_in_ready && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (!x_if.x_in_ready) chk("ready_timeout", 0, 1);
   endtask

   task automatic send(input logic signed [DW-1:0] v);
      @(negedge clk);
      wait_ready(200);
      x_if.x_in       = v;
      x_if.x_in_valid = 1'b1;
      @(negedge clk);
      x_if.x_in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((exp_q.size() != 0 || !x_if.x_in_ready) && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("drain_timeout", longint'(exp_q.size()), 0);
   endtask

   task automatic check_rezero();
      for (int i = 1; i <= NTAPS; i++) begin
         chk("rezero_ready_low", longint'(x_if.x_in_ready), 0);
         @(negedge clk);
      end
      chk("rezero_ready_rise", longint'(x_if.x_in_ready), 1);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int prev_t, t, nacc, ovr_cnt;
      logic signed [CW-1:0] c;

      reset           = 1'b1;
      clear           = 1'b0;
      x_if.x_in       = '0;
      x_if.x_in_valid = 1'b0;
      for (int k = 0; k < NTAPS; k++) begin
         coef_rom[k] = (k == 0) ? 16'sd32767 : 16'sd0;
         samp_mem[k] = 16'(k + 7);
      end

      repeat (4) @(negedge clk);
      chk("reset_y_out", longint'(y_out), 0);
      chk("reset_y_out_valid", longint'(y_out_valid), 0);
      chk("reset_overrun", longint'(overrun), 0);
      chk("reset_ready", longint'(x_if.x_in_ready), 0);

      // Release: zeroing writes in cycles 1..32, ready at 33
      reset = 1'b0;
      #1;
      for (int i = 1; i <= NTAPS; i++) begin
         chk("zero_we", longint'(samp_we), 1);
         chk("zero_addr", longint'(samp_waddr), longint'(i - 1));
         chk("zero_data", longint'(samp_wdata), 0);
         chk("zero_ready_low", longint'(x_if.x_in_ready), 0);
         @(negedge clk);
         #1;
      end
      chk("ready_rise", longint'(x_if.x_in_ready), 1);

      // Delta coefficients, ramp 1..40
      for (int v = 1; v <= 40; v++) send(16'(v));
      wait_drain();

      // Full-scale saturation
      for (int k = 0; k < NTAPS; k++) coef_rom[k] = 16'sd32767;
      repeat (34) send(16'sd32767);
      repeat (34) send(-16'sd32768);
      wait_drain();

      // Continuous offer: one accept per 37 cycles, overrun on every stalled cycle
      for (int k = 0; k < NTAPS; k++) coef_rom[k] = 16'($urandom_range(0, 65535));
      @(negedge clk);
      x_if.x_in       = 16'($urandom_range(0, 65535));
      x_if.x_in_valid = 1'b1;
      t = 0; nacc = 0; prev_t = 0; ovr_cnt = 0;
      while (nacc < 5 && t < 300) begin
         if (overrun) ovr_cnt++;
         if (x_if.x_in_ready) begin
            if (nacc > 0) begin
               chk("hold_accept_gap", longint'(t - prev_t), 37);
               chk("hold_overrun_count", longint'(ovr_cnt), 36);
            end
            prev_t  = t;
            ovr_cnt = 0;
            nacc++;
         end else begin
            x_if.x_in = 16'($urandom_range(0, 65535));
         end
         if (nacc < 5) begin
            @(negedge clk);
            t++;
         end
      end
      chk("hold_accepts", longint'(nacc), 5);
      @(negedge clk);
      x_if.x_in_valid = 1'b0;
      wait_drain();

      // Clear at RUN k=10: sample aborted, y_out holds, re-zero, re-warm-up
      @(negedge clk);
      wait_ready(200);
      x_if.x_in       = 16'sd12345;
      x_if.x_in_valid = 1'b1;
      @(negedge clk);
      x_if.x_in_valid = 1'b0;
      repeat (10) @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      check_rezero();
      chk("y_out_held", longint'(y_out), longint'(last_y));
      repeat (NTAPS + 2) send(16'($urandom_range(0, 65535)));
      wait_drain();

      // Offer and clear together in IDLE, then clear again mid-zeroing
      @(negedge clk);
      x_if.x_in       = 16'sd999;
      x_if.x_in_valid = 1'b1;
      clear           = 1'b1;
      @(negedge clk);
      x_if.x_in_valid = 1'b0;
      clear           = 1'b0;
      repeat (5) @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      check_rezero();

      // Symmetric coefficients, 70 samples across the pointer wrap
      for (int k = 0; k < NTAPS / 2; k++) begin
         c = 16'($signed(16'($urandom_range(0, 16383))) - 16'sd8192);
         coef_rom[k]             = c;
         coef_rom[NTAPS - 1 - k] = c;
      end
      repeat (70) send(16'($urandom_range(0, 65535)));
      wait_drain();

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   // Global time limit
   initial begin
      #2000000;
      n_bad++;
      $display("FAIL global_timeout: got=timeout want=finish");
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
